cop0_irq_ctrl: RTL and testbench

Parametrised successor to the single-interrupt coprocessor 0 in the pipelined MIPS core. It generalises the one external interrupt line to N_IRQ maskable lines, each with its own handler vector. Lines are level or edge sensitive, selected by a parameter. The block prioritises synchronous exceptions over interrupts, captures EPC from the correct pipeline stage, holds STATUS/CAUSE/EPC registers accessible by mtc0/mfc0, and runs a trap/handler/eret state machine. It drives the fetch redirect and the pipeline flush.

---
 rtl/cop0_irq_ctrl_if.sv | 35 +++
 rtl/cop0_irq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cop0_irq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop0_irq_ctrl_if.sv
// Pipeline <-> coprocessor 0 bus: interrupt lines, exception sources, PCs,
// mtc0/mfc0 register access, eret, and the redirect/flush outputs.
interface cop0_irq_ctrl_if #(
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] i_irq;
  logic             i_hold;
  logic             i_arithmetic_overflow;
  logic             i_unknown_command;
  logic             i_unknown_func;
  logic [31:0]      i_pc_execute;
  logic [31:0]      i_pc_decode;
  logic [31:0]      i_pc_fetch;
  logic             i_mtc0;
  logic [4:0]       i_address;
  logic [31:0]      i_data;
  logic             i_eret;
  logic             o_exception;
  logic [31:0]      o_handler_address;
  logic             o_epc_to_pc;
  logic [31:0]      o_epc;
  logic [31:0]      o_data;

  modport slave (
    input  i_irq, i_hold, i_arithmetic_overflow, i_unknown_command, i_unknown_func,
           i_pc_execute, i_pc_decode, i_pc_fetch, i_mtc0, i_address, i_data, i_eret,
    output o_exception, o_handler_address, o_epc_to_pc, o_epc, o_data
  );

  modport master (
    output i_irq, i_hold, i_arithmetic_overflow, i_unknown_command, i_unknown_func,
           i_pc_execute, i_pc_decode, i_pc_fetch, i_mtc0, i_address, i_data, i_eret,
    input  o_exception, o_handler_address, o_epc_to_pc, o_epc, o_data
  );
endinterface

// File: rtl/cop0_irq_ctrl.sv
// Coprocessor 0 with N_IRQ vectored interrupt lines: STATUS/CAUSE/EPC registers,
// exception-over-interrupt priority and a RUN/TRAP/HANDLER trap sequencer.
module cop0_irq_ctrl #(
  parameter int          N_IRQ        = 4,
  parameter bit          IRQ_EDGE     = 1'b0,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE   = 32'h10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  cop0_irq_ctrl_if.slave io_cop0
);

  typedef enum logic [1:0] {S_RUN, S_TRAP, S_HANDLER} state_t;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  state_t           r_state;
  logic             r_ie;
  logic             r_exl;
  logic [N_IRQ-1:0] r_im;
  logic [N_IRQ-1:0] r_ip;
  logic [N_IRQ-1:0] r_irq_q;
  logic [4:0]       r_exc_code;
  logic [31:0]      r_epc;
  logic [31:0]      r_vec;
  logic             r_epc_to_pc;

  state_t           w_state_nxt;
  logic             w_trap_entry;
  logic             w_eret_take;
  logic             w_sync;
  logic             w_irq_req;
  logic [N_IRQ-1:0] w_pend;
  logic [31:0]      w_irq_vec;
  logic [4:0]       w_exc_code;
  logic [31:0]      w_epc_sel;
  logic [31:0]      w_vec;
  logic             w_wr_status;
  logic             w_wr_cause;
  logic             w_wr_epc;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_ip_nxt;
  logic [31:0]      w_rdata;

  assign w_sync    = io_cop0.i_arithmetic_overflow | io_cop0.i_unknown_command
                   | io_cop0.i_unknown_func;
  assign w_pend    = r_ip & r_im;
  // EXL masks interrupts for the whole TRAP/HANDLER window
  assign w_irq_req = r_ie & ~r_exl & ~io_cop0.i_hold & (|w_pend);

  // Lowest pending line wins: scan downwards so the last hit is the smallest index
  always_comb begin
    w_irq_vec = HANDLER_BASE + VEC_STRIDE;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_pend[k]) w_irq_vec = HANDLER_BASE + VEC_STRIDE * 32'(k + 1);
    end
  end

  always_comb begin
    w_exc_code = 5'd0;
    w_epc_sel  = io_cop0.i_pc_fetch;
    w_vec      = w_irq_vec;
    if (io_cop0.i_arithmetic_overflow) begin
      w_exc_code = 5'd12;
      w_epc_sel  = io_cop0.i_pc_execute;
      w_vec      = HANDLER_BASE;
    end else if (io_cop0.i_unknown_command | io_cop0.i_unknown_func) begin
      w_exc_code = 5'd10;
      w_epc_sel  = io_cop0.i_pc_decode;
      w_vec      = HANDLER_BASE;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_trap_entry = 1'b0;
    w_eret_take  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_sync | w_irq_req) begin
          w_state_nxt  = S_TRAP;
          w_trap_entry = 1'b1;
        end
      end
      S_TRAP: w_state_nxt = S_HANDLER;
      S_HANDLER: begin
        // A fault inside the handler beats a simultaneous eret
        if (w_sync) begin
          w_state_nxt  = S_TRAP;
          w_trap_entry = 1'b1;
        end else if (io_cop0.i_eret) begin
          w_state_nxt = S_RUN;
          w_eret_take = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_wr_status = io_cop0.i_mtc0 & (io_cop0.i_address == A_STATUS) & ~w_trap_entry;
  assign w_wr_cause  = io_cop0.i_mtc0 & (io_cop0.i_address == A_CAUSE)  & ~w_trap_entry;
  assign w_wr_epc    = io_cop0.i_mtc0 & (io_cop0.i_address == A_EPC)    & ~w_trap_entry;
  assign w_clr       = w_wr_cause ? io_cop0.i_data[8 +: N_IRQ] : '0;

  // Edge mode: a fresh rising edge outranks a write-1 clear in the same cycle
  always_comb begin
    if (IRQ_EDGE) w_ip_nxt = (r_ip & ~w_clr) | (io_cop0.i_irq & ~r_irq_q);
    else          w_ip_nxt = io_cop0.i_irq;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RUN;
      r_ie        <= 1'b0;
      r_exl       <= 1'b0;
      r_im        <= '0;
      r_ip        <= '0;
      r_irq_q     <= '0;
      r_exc_code  <= 5'd0;
      r_epc       <= 32'd0;
      r_vec       <= 32'd0;
      r_epc_to_pc <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_epc_to_pc <= w_eret_take;
      r_irq_q     <= io_cop0.i_irq;
      r_ip        <= w_ip_nxt;
      if (w_trap_entry) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_exc_code;
        r_vec      <= w_vec;
        // Re-entry from HANDLER keeps the original return address
        if (r_state == S_RUN) r_epc <= w_epc_sel;
      end else begin
        if (w_eret_take) r_exl <= 1'b0;
        if (w_wr_status) begin
          r_ie <= io_cop0.i_data[0];
          r_im <= io_cop0.i_data[8 +: N_IRQ];
        end
        if (w_wr_epc) r_epc <= io_cop0.i_data;
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (io_cop0.i_address)
      A_STATUS: begin
        w_rdata[0]           = r_ie;
        w_rdata[1]           = r_exl;
        w_rdata[8 +: N_IRQ]  = r_im;
      end
      A_CAUSE: begin
        w_rdata[6:2]         = r_exc_code;
        w_rdata[8 +: N_IRQ]  = r_ip;
      end
      A_EPC:   w_rdata = r_epc;
      default: w_rdata = 32'd0;
    endcase
  end

  assign io_cop0.o_exception       = (r_state == S_TRAP);
  assign io_cop0.o_handler_address = (r_state == S_TRAP) ? r_vec : 32'd0;
  assign io_cop0.o_epc_to_pc       = r_epc_to_pc;
  assign io_cop0.o_epc             = r_epc;
  assign io_cop0.o_data            = w_rdata;

endmodule

// File: tb/tb_cop0_irq_ctrl.sv
// Scoreboard bench for cop0_irq_ctrl: a level-mode and an edge-mode instance,
// directed stimulus pushes expected events, a negedge monitor pops and compares.
module tb_cop0_irq_ctrl;

  localparam int K_EXC = 0;
  localparam int K_EPC = 1;
  localparam int K_RD  = 2;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] val;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_l = 1'b0;
  logic rd_e = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  cop0_irq_ctrl_if #(.N_IRQ(4)) ifl ();
  cop0_irq_ctrl_if #(.N_IRQ(4)) ife ();

  cop0_irq_ctrl #(.N_IRQ(4), .IRQ_EDGE(1'b0), .HANDLER_BASE(32'h100), .VEC_STRIDE(32'h10))
    dut_l (.i_clk(clk), .i_rst_n(rst_n), .io_cop0(ifl));
  cop0_irq_ctrl #(.N_IRQ(4), .IRQ_EDGE(1'b1), .HANDLER_BASE(32'h100), .VEC_STRIDE(32'h10))
    dut_e (.i_clk(clk), .i_rst_n(rst_n), .io_cop0(ife));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int k, input logic [31:0] v, input int c,
                      input string n);
    exp_t e;
    e.dut = d; e.kind = k; e.val = v; e.cyc = c; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic rd(input int d, input logic [4:0] a, input logic [31:0] v, input string n);
    if (d == 0) begin ifl.i_address = a; rd_l = 1'b1; end
    else        begin ife.i_address = a; rd_e = 1'b1; end
    push(d, K_RD, v, cyc, n);
    tick();
    rd_l = 1'b0;
    rd_e = 1'b0;
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [31:0] v);
    if (d == 0) begin ifl.i_mtc0 = 1'b1; ifl.i_address = a; ifl.i_data = v; end
    else        begin ife.i_mtc0 = 1'b1; ife.i_address = a; ife.i_data = v; end
    tick();
    ifl.i_mtc0 = 1'b0;
    ife.i_mtc0 = 1'b0;
  endtask

  task automatic check_ev(input int d, input int k, input logic [31:0] v);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: dut=%0d kind=%0d value=%h cycle=%0d, none expected",
               d, k, v, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.dut != d || e.kind != k || e.val != v || (e.cyc >= 0 && e.cyc != cyc)) begin
        failures++;
        $display("FAIL %s: got dut=%0d kind=%0d value=%h cycle=%0d, expected dut=%0d kind=%0d value=%h cycle=%0d",
                 e.name, d, k, v, cyc, e.dut, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ifl.o_exception) check_ev(0, K_EXC, ifl.o_handler_address);
    if (ifl.o_epc_to_pc) check_ev(0, K_EPC, ifl.o_epc);
    if (rd_l)            check_ev(0, K_RD,  ifl.o_data);
    if (ife.o_exception) check_ev(1, K_EXC, ife.o_handler_address);
    if (ife.o_epc_to_pc) check_ev(1, K_EPC, ife.o_epc);
    if (rd_e)            check_ev(1, K_RD,  ife.o_data);
  end

  task automatic clear_if();
    ifl.i_irq = '0; ifl.i_hold = 0; ifl.i_arithmetic_overflow = 0;
    ifl.i_unknown_command = 0; ifl.i_unknown_func = 0; ifl.i_pc_execute = '0;
    ifl.i_pc_decode = '0; ifl.i_pc_fetch = '0; ifl.i_mtc0 = 0; ifl.i_address = '0;
    ifl.i_data = '0; ifl.i_eret = 0;
    ife.i_irq = '0; ife.i_hold = 0; ife.i_arithmetic_overflow = 0;
    ife.i_unknown_command = 0; ife.i_unknown_func = 0; ife.i_pc_execute = '0;
    ife.i_pc_decode = '0; ife.i_pc_fetch = '0; ife.i_mtc0 = 0; ife.i_address = '0;
    ife.i_data = '0; ife.i_eret = 0;
  endtask

  initial begin
    clear_if();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values
    rd(0, 5'd12, 32'h0, "reset_status");
    rd(0, 5'd13, 32'h0, "reset_cause");
    rd(0, 5'd14, 32'h0, "reset_epc");
    rd(0, 5'd20, 32'h0, "unmapped_read");

    // Enable IE and all masks, single interrupt on line 2
    wr(0, 5'd12, 32'h0F01);
    rd(0, 5'd12, 32'h0F01, "status_after_write");
    ifl.i_pc_fetch = 32'h40;
    ifl.i_irq = 4'b0100;
    push(0, K_EXC, 32'h130, cyc + 2, "irq2_vector");
    tick();
    ifl.i_irq = 4'b0000;
    tick();
    tick();
    rd(0, 5'd13, 32'h0, "irq2_cause");
    rd(0, 5'd14, 32'h40, "irq2_epc");
    rd(0, 5'd12, 32'h0F03, "irq2_exl_set");

    // Lines 1 and 3 pending while in handler: masked until eret, then line 1 first
    ifl.i_irq = 4'b1010;
    ifl.i_pc_fetch = 32'h50;
    tick();
    tick();
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h40, cyc + 1, "eret_to_40");
    tick();
    ifl.i_eret = 1'b0;
    rd(0, 5'd12, 32'h0F01, "eret_exl_clear");
    push(0, K_EXC, 32'h120, cyc, "irq1_vector");
    ifl.i_irq = 4'b1000;
    tick();
    rd(0, 5'd14, 32'h50, "irq1_epc");
    ifl.i_pc_fetch = 32'h60;
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h50, cyc + 1, "eret_to_50");
    tick();
    ifl.i_eret = 1'b0;
    push(0, K_EXC, 32'h140, cyc + 1, "irq3_vector");
    ifl.i_irq = 4'b0000;
    tick();
    tick();
    rd(0, 5'd14, 32'h60, "irq3_epc");

    // Overflow and unknown_func together: overflow wins
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h60, cyc + 1, "eret_to_60");
    tick();
    ifl.i_eret = 1'b0;
    ifl.i_arithmetic_overflow = 1'b1;
    ifl.i_unknown_func = 1'b1;
    ifl.i_pc_execute = 32'h88;
    ifl.i_pc_decode = 32'h8C;
    push(0, K_EXC, 32'h100, cyc + 1, "ovf_vector");
    tick();
    ifl.i_arithmetic_overflow = 1'b0;
    ifl.i_unknown_func = 1'b0;
    tick();
    rd(0, 5'd13, 32'h30, "ovf_exccode");
    rd(0, 5'd14, 32'h88, "ovf_epc");

    // Fault in handler with eret in the same cycle: fault wins, EPC unchanged
    ifl.i_unknown_command = 1'b1;
    ifl.i_pc_decode = 32'h99;
    ifl.i_eret = 1'b1;
    push(0, K_EXC, 32'h100, cyc + 1, "nested_fault_vector");
    tick();
    ifl.i_unknown_command = 1'b0;
    ifl.i_eret = 1'b0;
    tick();
    rd(0, 5'd13, 32'h28, "nested_exccode");
    rd(0, 5'd14, 32'h88, "nested_epc_kept");

    // EPC writable in handler
    wr(0, 5'd14, 32'h200);
    rd(0, 5'd14, 32'h200, "epc_write");
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h200, cyc + 1, "eret_to_200");
    tick();
    ifl.i_eret = 1'b0;

    // mtc0 dropped on trap entry; EXL not writable
    ifl.i_arithmetic_overflow = 1'b1;
    ifl.i_pc_execute = 32'h300;
    ifl.i_mtc0 = 1'b1;
    ifl.i_address = 5'd12;
    ifl.i_data = 32'h0;
    push(0, K_EXC, 32'h100, cyc + 1, "ovf2_vector");
    tick();
    ifl.i_arithmetic_overflow = 1'b0;
    ifl.i_mtc0 = 1'b0;
    tick();
    rd(0, 5'd12, 32'h0F03, "mtc0_dropped_on_trap");
    rd(0, 5'd14, 32'h300, "ovf2_epc");
    wr(0, 5'd12, 32'h0F01);
    rd(0, 5'd12, 32'h0F03, "exl_read_only");
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h300, cyc + 1, "eret_to_300");
    tick();
    ifl.i_eret = 1'b0;
    rd(0, 5'd12, 32'h0F01, "status_after_eret");

    // i_hold blocks interrupts only
    ifl.i_hold = 1'b1;
    ifl.i_irq = 4'b0001;
    ifl.i_pc_fetch = 32'h70;
    tick();
    tick();
    tick();
    tick();
    ifl.i_hold = 1'b0;
    push(0, K_EXC, 32'h110, cyc + 1, "irq0_after_hold");
    tick();
    ifl.i_irq = 4'b0000;
    tick();
    rd(0, 5'd14, 32'h70, "irq0_epc");
    ifl.i_eret = 1'b1;
    push(0, K_EPC, 32'h70, cyc + 1, "eret_to_70");
    tick();
    ifl.i_eret = 1'b0;
    ifl.i_hold = 1'b1;
    ifl.i_unknown_command = 1'b1;
    ifl.i_pc_decode = 32'hA4;
    push(0, K_EXC, 32'h100, cyc + 1, "ucmd_during_hold");
    tick();
    ifl.i_unknown_command = 1'b0;
    ifl.i_hold = 1'b0;
    tick();
    rd(0, 5'd14, 32'hA4, "ucmd_epc");
    rd(0, 5'd13, 32'h28, "ucmd_exccode");

    // Reset during HANDLER, then a stray eret
    rst_n = 1'b0;
    rd(0, 5'd12, 32'h0, "midreset_status");
    rd(0, 5'd14, 32'h0, "midreset_epc");
    rd(0, 5'd13, 32'h0, "midreset_cause");
    rst_n = 1'b1;
    ifl.i_eret = 1'b1;
    tick();
    ifl.i_eret = 1'b0;
    tick();
    tick();

    // Edge-sensitive instance: sticky pending
    ife.i_irq = 4'b0001;
    tick();
    ife.i_irq = 4'b0000;
    tick();
    tick();
    rd(1, 5'd13, 32'h100, "edge_sticky");
    wr(1, 5'd13, 32'h100);
    rd(1, 5'd13, 32'h0, "edge_clear");
    ife.i_irq = 4'b0001;
    ife.i_mtc0 = 1'b1;
    ife.i_address = 5'd13;
    ife.i_data = 32'h100;
    tick();
    ife.i_mtc0 = 1'b0;
    ife.i_irq = 4'b0000;
    rd(1, 5'd13, 32'h100, "edge_beats_clear");
    wr(1, 5'd13, 32'h100);
    ife.i_irq = 4'b0001;
    tick();
    tick();
    rd(1, 5'd13, 32'h100, "edge_held_set");
    wr(1, 5'd13, 32'h100);
    rd(1, 5'd13, 32'h0, "held_high_no_reset");
    ife.i_irq = 4'b0000;
    tick();
    tick();

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: event never seen, expected value=%h cycle=%0d", e.name, e.val, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
